mips32_prog_loader: RTL and testbench

Byte-stream program loader that fills the processor's 32-bit instruction/data memory before execution. It is the writer for the memory the pipelined MIPS32 core reads. It accepts bytes over a valid/ready handshake and packs them big-endian into 32-bit words. It writes each word to sequential addresses and asserts cpu_run once a word carrying the HLT opcode (6'b111111) has been stored. It sits between a host/debug byte source and the memory write port; the core is held idle until cpu_run rises.

---
 rtl/mips32_prog_loader_if.sv | 22 ++
 rtl/mips32_prog_loader.sv | 101 ++++++++++
 tb/tb_mips32_prog_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// master is the loader side, slave is the host/memory side.
interface mips32_prog_loader_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mips32_prog_loader.sv
// Packs a big-endian byte stream into 32-bit words, writes them to sequential
// memory addresses and releases the core once a HLT word has been stored.
module mips32_prog_loader #(
   parameter int           ADDR_W    = 10,
   parameter int           MAX_WORDS = 1024,
   parameter int           BASE_ADDR = 0,
   parameter logic [5:0]   HLT_OP    = 6'b111111
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   mips32_prog_loader_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err_overflow,
   output logic [ADDR_W:0]      word_count,
   output logic                 cpu_run
);
   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

   state_t          state;
   logic [1:0]      byte_idx;
   logic [31:0]     word;
   logic [ADDR_W:0] next_count;

   assign next_count = word_count + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         byte_idx      <= 2'd0;
         word          <= 32'd0;
         bus.in_ready  <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= 32'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err_overflow  <= 1'b0;
         word_count    <= '0;
         cpu_run       <= 1'b0;
      end else begin
         bus.mem_we <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state        <= LOAD;
                  byte_idx     <= 2'd0;
                  bus.in_ready <= 1'b1;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  word_count   <= '0;
                  err_overflow <= 1'b0;
                  cpu_run      <= 1'b0;
               end
            end
            LOAD: begin
               if (bus.in_valid && bus.in_ready) begin
                  word     <= {word[23:0], bus.in_data};
                  byte_idx <= byte_idx + 2'd1;
                  // Last byte of the word: present it to memory on the same edge.
                  if (byte_idx == 2'd3) begin
                     state         <= WRITE;
                     bus.in_ready  <= 1'b0;
                     bus.mem_we    <= 1'b1;
                     bus.mem_addr  <= ADDR_W'(BASE_ADDR) + word_count[ADDR_W-1:0];
                     bus.mem_wdata <= {word[23:0], bus.in_data};
                  end
               end
            end
            WRITE: begin
               word_count <= next_count;
               // HLT wins over overflow, even on the last permitted word.
               if (bus.mem_wdata[31:26] == HLT_OP) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  cpu_run <= 1'b1;
               end else if (next_count == MAX_CNT) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  err_overflow <= 1'b1;
               end else begin
                  state        <= LOAD;
                  byte_idx     <= 2'd0;
                  bus.in_ready <= 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               bus.in_ready <= 1'b0;
               busy         <= 1'b0;
               done         <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mips32_prog_loader.sv
// Scoreboard bench for mips32_prog_loader: three instances cover default,
// MAX_WORDS=4 and BASE_ADDR=16 configurations.
module tb_mips32_prog_loader;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start_s [3];
   logic        valid_s [3];
   logic [7:0]  data_s  [3];
   logic        ready_s [3];
   logic        we_s    [3];
   logic [9:0]  addr_s  [3];
   logic [31:0] wdata_s [3];
   logic        busy_s  [3];
   logic        done_s  [3];
   logic        err_s   [3];
   logic [10:0] wc_s    [3];
   logic        run_s   [3];

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mips32_prog_loader_if #(.ADDR_W(10)) bus ();
      assign bus.in_valid = valid_s[gi];
      assign bus.in_data  = data_s[gi];
      assign ready_s[gi]  = bus.in_ready;
      assign we_s[gi]     = bus.mem_we;
      assign addr_s[gi]   = bus.mem_addr;
      assign wdata_s[gi]  = bus.mem_wdata;

      mips32_prog_loader #(
         .ADDR_W    (10),
         .MAX_WORDS ((gi == 1) ? 4 : 1024),
         .BASE_ADDR ((gi == 2) ? 16 : 0),
         .HLT_OP    (6'b111111)
      ) dut (
         .clk          (clk),
         .rst          (rst),
         .start        (start_s[gi]),
         .bus          (bus),
         .busy         (busy_s[gi]),
         .done         (done_s[gi]),
         .err_overflow (err_s[gi]),
         .word_count   (wc_s[gi]),
         .cpu_run      (run_s[gi])
      );
   end

   typedef struct {
      int          dut;
      logic [9:0]  addr;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   exp_wc  [3];
   int   base_of [3];
   bit   phase;

   // Advance to the next falling edge and check any write the DUTs made.
   task automatic tick();
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (busy_s[k] && done_s[k]) begin
            fails++;
            $display("FAIL busy_done dut%0d: busy=%b done=%b, required not both high", k, busy_s[k], done_s[k]);
         end
         if (we_s[k]) begin
            if (sb.size() == 0 || sb[0].dut != k) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write dut%0d: addr=%h data=%h, required no write", k, addr_s[k], wdata_s[k]);
            end else begin
               exp_t e;
               e = sb.pop_front();
               tests += 4;
               if (addr_s[k] !== e.addr) begin
                  fails++;
                  $display("FAIL write_addr dut%0d: got %h, required %h", k, addr_s[k], e.addr);
               end
               if (wdata_s[k] !== e.data) begin
                  fails++;
                  $display("FAIL write_data dut%0d: got %h, required %h", k, wdata_s[k], e.data);
               end
               if (cyc != e.due) begin
                  fails++;
                  $display("FAIL write_latency dut%0d: write at cycle %0d, required %0d", k, cyc, e.due);
               end
               if (ready_s[k] !== 1'b0) begin
                  fails++;
                  $display("FAIL ready_in_write dut%0d: in_ready=%b, required 0", k, ready_s[k]);
               end
               $display("[TB] dut%0d write addr=%0d data=%h", k, addr_s[k], wdata_s[k]);
            end
         end
      end
   endtask

   task automatic send_byte(input int k, input logic [31:0] w, input int idx,
                            input bit toggle, input bit st);
      bit          hs = 1'b0;
      int          n  = 0;
      logic [7:0]  b;
      b = w[31-8*idx -: 8];
      while (!hs && n < 40) begin
         phase       = toggle ? ~phase : 1'b1;
         valid_s[k]  = phase;
         data_s[k]   = phase ? b : ~b;
         start_s[k]  = st && (n == 0);
         hs          = valid_s[k] && ready_s[k];
         if (hs && idx == 3) begin
            sb.push_back('{k, 10'(base_of[k] + exp_wc[k]), w, cyc + 1});
            exp_wc[k]++;
         end
         tick();
         n++;
      end
      start_s[k] = 1'b0;
      valid_s[k] = 1'b0;
      tests++;
      if (!hs) begin
         fails++;
         $display("FAIL byte_timeout dut%0d: byte %0d of %h not accepted, required handshake", k, idx, w);
      end
   endtask

   task automatic send_word(input int k, input logic [31:0] w, input bit toggle);
      for (int i = 0; i < 4; i++) send_byte(k, w, i, toggle, 1'b0);
   endtask

   task automatic start_load(input int k);
      start_s[k] = 1'b1;
      tick();
      start_s[k] = 1'b0;
      exp_wc[k]  = 0;
      phase      = 1'b0;
      tests++;
      if ({busy_s[k], done_s[k], run_s[k], err_s[k], wc_s[k]} !== {3'b100, 1'b0, 11'd0}) begin
         fails++;
         $display("FAIL start_state dut%0d: busy=%b done=%b run=%b err=%b wc=%0d, required 1 0 0 0 0",
                  k, busy_s[k], done_s[k], run_s[k], err_s[k], wc_s[k]);
      end
   endtask

   task automatic wait_done(input int k, input int wc, input bit err, input bit run);
      int n = 0;
      while (!done_s[k] && n < 30) begin
         tick();
         n++;
      end
      tests += 3;
      if (done_s[k] !== 1'b1 || busy_s[k] !== 1'b0) begin
         fails++;
         $display("FAIL done_state dut%0d: done=%b busy=%b, required 1 0", k, done_s[k], busy_s[k]);
      end
      if (wc_s[k] !== 11'(wc) || err_s[k] !== err || run_s[k] !== run) begin
         fails++;
         $display("FAIL final_flags dut%0d: wc=%0d err=%b run=%b, required wc=%0d err=%b run=%b",
                  k, wc_s[k], err_s[k], run_s[k], wc, err, run);
      end
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL missing_writes dut%0d: %0d writes outstanding, required 0", k, sb.size());
         sb.delete();
      end
      $display("[TB] dut%0d done wc=%0d err=%b run=%b", k, wc_s[k], err_s[k], run_s[k]);
   endtask

   task automatic check_zero(input int k, input string name);
      logic [58:0] v;
      v = {ready_s[k], we_s[k], addr_s[k], wdata_s[k], busy_s[k], done_s[k], err_s[k], wc_s[k], run_s[k]};
      tests++;
      if (v !== 59'd0) begin
         fails++;
         $display("FAIL %s dut%0d: outputs=%h, required all zero", name, k, v);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < 3; k++) check_zero(k, "reset_outputs");
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      start_load(0);
      send_word(0, 32'h2801000A, 1'b0);
      send_word(0, 32'hFC000000, 1'b0);
      wait_done(0, 2, 1'b0, 1'b1);
   endtask

   task automatic test_stall();
      start_load(0);
      send_word(0, 32'h2801000A, 1'b1);
      send_word(0, 32'hFC000000, 1'b1);
      wait_done(0, 2, 1'b0, 1'b1);
   endtask

   task automatic test_overflow();
      start_load(1);
      for (int i = 1; i <= 4; i++) send_word(1, 32'(i), 1'b0);
      wait_done(1, 4, 1'b1, 1'b0);
      start_load(1);
      for (int i = 1; i <= 3; i++) send_word(1, 32'(i), 1'b0);
      send_word(1, 32'hFC000000, 1'b0);
      wait_done(1, 4, 1'b0, 1'b1);
   endtask

   task automatic test_mid_reset();
      start_load(0);
      send_word(0, 32'h2801000A, 1'b0);
      send_byte(0, 32'hFC000000, 0, 1'b0, 1'b0);
      send_byte(0, 32'hFC000000, 1, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      check_zero(0, "mid_reset_outputs");
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check_zero(0, "post_reset_idle");
      start_load(0);
      send_word(0, 32'hFC000000, 1'b0);
      wait_done(0, 1, 1'b0, 1'b1);
   endtask

   task automatic test_restart_base();
      start_load(2);
      send_word(2, 32'hFC000001, 1'b0);
      wait_done(2, 1, 1'b0, 1'b1);
      start_load(2);
      send_byte(2, 32'hFC0000AB, 0, 1'b0, 1'b0);
      send_byte(2, 32'hFC0000AB, 1, 1'b0, 1'b1);
      send_byte(2, 32'hFC0000AB, 2, 1'b0, 1'b1);
      send_byte(2, 32'hFC0000AB, 3, 1'b0, 1'b0);
      wait_done(2, 1, 1'b0, 1'b1);
   endtask

   initial begin
      rst     = 1'b1;
      base_of = '{0, 0, 16};
      for (int k = 0; k < 3; k++) begin
         start_s[k] = 1'b0;
         valid_s[k] = 1'b0;
         data_s[k]  = 8'd0;
         exp_wc[k]  = 0;
      end
      test_reset();
      test_basic();
      test_stall();
      test_overflow();
      test_mid_reset();
      test_restart_base();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
